// File: rtl/bp_stream_uart_master.sv
// Byte-stream to word-stream bridge: host bytes are packed into address/data writes, and
// returned words are unpacked into host bytes. Optional macro BP_STREAM_UART_SYNC_EN adds an 8'hA5 sync hunt.
module bp_stream_uart_master #(
  parameter int unsigned stream_addr_width_p = 32,
  parameter int unsigned stream_data_width_p = 32
) (
  input  logic                           clk_i,
  input  logic                           reset_n_i,

  input  logic                           rx_v_i,
  input  logic [7:0]                     rx_data_i,
  output logic                           rx_ready_o,

  output logic                           stream_v_o,
  output logic [stream_addr_width_p-1:0] stream_addr_o,
  output logic [stream_data_width_p-1:0] stream_data_o,
  input  logic                           stream_yumi_i,

  input  logic                           stream_v_i,
  input  logic [stream_data_width_p-1:0] stream_data_i,
  output logic                           stream_ready_o,

  output logic                           tx_v_o,
  output logic [7:0]                     tx_data_o,
  input  logic                           tx_ready_i
);

  localparam int unsigned FrameW     = stream_addr_width_p + stream_data_width_p;
  localparam int unsigned FrameBytes = FrameW / 8;
  localparam int unsigned WordBytes  = stream_data_width_p / 8;
  localparam int unsigned RxCntW     = (FrameBytes > 1) ? $clog2(FrameBytes) : 1;
  localparam int unsigned TxCntW     = (WordBytes > 1) ? $clog2(WordBytes) : 1;
  localparam logic [RxCntW-1:0] RxLast = RxCntW'(FrameBytes - 1);
  localparam logic [TxCntW-1:0] TxLast = TxCntW'(WordBytes - 1);

`ifdef BP_STREAM_UART_SYNC_EN
  typedef enum logic [1:0] {StCollect, StIssue, StHunt} rx_state_e;
  localparam rx_state_e RxHome = StHunt;
`else
  typedef enum logic [0:0] {StCollect, StIssue} rx_state_e;
  localparam rx_state_e RxHome = StCollect;
`endif

  typedef enum logic [0:0] {StIdle, StSend} tx_state_e;

  rx_state_e             rx_state_q, rx_state_d;
  logic [RxCntW-1:0]     rx_cnt_q, rx_cnt_d;
  logic [FrameW-1:0]     frame_q, frame_d;

  tx_state_e                     tx_state_q, tx_state_d;
  logic [TxCntW-1:0]             tx_cnt_q, tx_cnt_d;
  logic [stream_data_width_p-1:0] word_q, word_d;

  // RX path: bytes shift in from the top so the first byte ends up in the LSB.
  always_comb begin
    rx_state_d = rx_state_q;
    rx_cnt_d   = rx_cnt_q;
    frame_d    = frame_q;
    rx_ready_o = 1'b0;
    stream_v_o = 1'b0;
    unique case (rx_state_q)
      StCollect: begin
        rx_ready_o = 1'b1;
        if (rx_v_i) begin
          frame_d = {rx_data_i, frame_q[FrameW-1:8]};
          if (rx_cnt_q == RxLast) begin
            rx_cnt_d   = '0;
            rx_state_d = StIssue;
          end else begin
            rx_cnt_d = rx_cnt_q + 1'b1;
          end
        end
      end
      StIssue: begin
        stream_v_o = 1'b1;
        if (stream_yumi_i) begin
          rx_state_d = RxHome;
        end
      end
`ifdef BP_STREAM_UART_SYNC_EN
      StHunt: begin
        rx_ready_o = 1'b1;
        if (rx_v_i && (rx_data_i == 8'hA5)) begin
          rx_state_d = StCollect;
        end
      end
`endif
      default: rx_state_d = RxHome;
    endcase
  end

  assign stream_addr_o = frame_q[stream_addr_width_p-1:0];
  assign stream_data_o = frame_q[FrameW-1:stream_addr_width_p];

  // TX path: the byte on tx_data_o is always the LSB of the shifting word register.
  always_comb begin
    tx_state_d     = tx_state_q;
    tx_cnt_d       = tx_cnt_q;
    word_d         = word_q;
    stream_ready_o = 1'b0;
    tx_v_o         = 1'b0;
    unique case (tx_state_q)
      StIdle: begin
        stream_ready_o = 1'b1;
        if (stream_v_i) begin
          word_d     = stream_data_i;
          tx_cnt_d   = '0;
          tx_state_d = StSend;
        end
      end
      StSend: begin
        tx_v_o = 1'b1;
        if (tx_ready_i) begin
          word_d = word_q >> 8;
          if (tx_cnt_q == TxLast) begin
            tx_cnt_d   = '0;
            tx_state_d = StIdle;
          end else begin
            tx_cnt_d = tx_cnt_q + 1'b1;
          end
        end
      end
      default: tx_state_d = StIdle;
    endcase
  end

  assign tx_data_o = word_q[7:0];

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      rx_state_q <= RxHome;
      rx_cnt_q   <= '0;
      frame_q    <= '0;
      tx_state_q <= StIdle;
      tx_cnt_q   <= '0;
      word_q     <= '0;
    end else begin
      rx_state_q <= rx_state_d;
      rx_cnt_q   <= rx_cnt_d;
      frame_q    <= frame_d;
      tx_state_q <= tx_state_d;
      tx_cnt_q   <= tx_cnt_d;
      word_q     <= word_d;
    end
  end

endmodule

// File: tb/tb_bp_stream_uart_master.sv
// Directed bench for bp_stream_uart_master: frame packing, stream handshake stalls, word
// unpacking with host back-pressure, mid-operation reset and concurrent RX/TX timing.
module tb_bp_stream_uart_master;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        rx_v = 1'b0;
  logic [7:0]  rx_data = '0;
  logic        rx_ready;
  logic        stream_v_out;
  logic [31:0] stream_addr;
  logic [31:0] stream_data_out;
  logic        stream_yumi = 1'b0;
  logic        stream_v_in = 1'b0;
  logic [31:0] stream_data_in = '0;
  logic        stream_ready;
  logic        tx_v;
  logic [7:0]  tx_data;
  logic        tx_ready = 1'b0;

  bp_stream_uart_master #(
    .stream_addr_width_p(32),
    .stream_data_width_p(32)
  ) dut (
    .clk_i         (clk),
    .reset_n_i     (reset_n),
    .rx_v_i        (rx_v),
    .rx_data_i     (rx_data),
    .rx_ready_o    (rx_ready),
    .stream_v_o    (stream_v_out),
    .stream_addr_o (stream_addr),
    .stream_data_o (stream_data_out),
    .stream_yumi_i (stream_yumi),
    .stream_v_i    (stream_v_in),
    .stream_data_i (stream_data_in),
    .stream_ready_o(stream_ready),
    .tx_v_o        (tx_v),
    .tx_data_o     (tx_data),
    .tx_ready_i    (tx_ready)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int v_cycles = 0;
  logic [31:0] wr_addr_q[$];
  logic [31:0] wr_data_q[$];

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (stream_v_out) v_cycles <= v_cycles + 1;
    if (stream_v_out && stream_yumi) begin
      wr_addr_q.push_back(stream_addr);
      wr_data_q.push_back(stream_data_out);
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout required completion");
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic [7:0]  b [8];
    logic [31:0] exp_addr;
    logic [31:0] exp_data;
  } rx_vec_t;

  typedef struct {
    logic [31:0] word;
    bit          toggle;
    logic [7:0]  exp [4];
  } tx_vec_t;

  rx_vec_t rx_vecs [4];
  tx_vec_t tx_vecs [2];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h required %h", name, act, exp);
    end
  endtask

  task automatic send_byte(input logic [7:0] b);
    bit done = 1'b0;
    rx_v    = 1'b1;
    rx_data = b;
    for (int w = 0; w < 50 && !done; w++) begin
      @(negedge clk);
      if (rx_ready) done = 1'b1;
      @(posedge clk);
    end
    #1 rx_v = 1'b0;
    if (!done) check("rx_accept_timeout", 32'd0, 32'd1);
  endtask

  task automatic send_frame(input logic [7:0] b [8]);
`ifdef BP_STREAM_UART_SYNC_EN
    send_byte(8'hA5);
`endif
    for (int i = 0; i < 8; i++) send_byte(b[i]);
  endtask

  task automatic wait_write(input int base);
    bit seen = 1'b0;
    for (int w = 0; w < 50 && !seen; w++) begin
      @(posedge clk);
      if (wr_addr_q.size() > base) seen = 1'b1;
    end
    #1;
    if (!seen) check("write_timeout", 32'd0, 32'd1);
  endtask

  task automatic run_rx(input logic [7:0] b [8], output int elapsed);
    int t0 = cyc;
    int base = wr_addr_q.size();
    send_frame(b);
    wait_write(base);
    elapsed = cyc - t0;
  endtask

  task automatic run_tx(input logic [31:0] word, input bit toggle,
                        output logic [7:0] got [4], output int n, output int elapsed);
    int   t0 = cyc;
    bit   hold_valid = 1'b0;
    logic [7:0] hold_byte = '0;
    n = 0;
    for (int i = 0; i < 4; i++) got[i] = '0;
    stream_v_in    = 1'b1;
    stream_data_in = word;
    @(negedge clk);
    check("stream_ready_idle", {31'd0, stream_ready}, 32'd1);
    @(posedge clk);
    #1 stream_v_in = 1'b0;
    for (int c = 0; c < 60 && n < 4; c++) begin
      tx_ready = toggle ? c[0] : 1'b1;
      @(negedge clk);
      check("tx_v_busy", {31'd0, tx_v}, 32'd1);
      check("stream_ready_busy", {31'd0, stream_ready}, 32'd0);
      if (hold_valid) check("tx_data_hold", {24'd0, tx_data}, {24'd0, hold_byte});
      if (tx_ready) begin
        got[n] = tx_data;
        n++;
        hold_valid = 1'b0;
      end else begin
        hold_valid = 1'b1;
        hold_byte  = tx_data;
      end
      @(posedge clk);
      #1;
    end
    tx_ready = 1'b0;
    elapsed  = cyc - t0;
    @(negedge clk);
    check("tx_done_ready", {31'd0, stream_ready}, 32'd1);
    check("tx_done_v", {31'd0, tx_v}, 32'd0);
    @(posedge clk);
    #1;
  endtask

  initial begin
    int base, vbase, n, el_rx_a, el_tx_a, el_rx_b, el_tx_b;
    logic [7:0] got [4];

    rx_vecs[0].b = '{8'h10, 8'h00, 8'h00, 8'h00, 8'hEF, 8'hBE, 8'hAD, 8'hDE};
    rx_vecs[0].exp_addr = 32'h0000_0010;  rx_vecs[0].exp_data = 32'hDEAD_BEEF;
    rx_vecs[1].b = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07, 8'h08};
    rx_vecs[1].exp_addr = 32'h0403_0201;  rx_vecs[1].exp_data = 32'h0807_0605;
    rx_vecs[2].b = '{8'h20, 8'h00, 8'h00, 8'h00, 8'h01, 8'h00, 8'h00, 8'h00};
    rx_vecs[2].exp_addr = 32'h0000_0020;  rx_vecs[2].exp_data = 32'h0000_0001;
    rx_vecs[3].b = '{8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'h00, 8'h00, 8'h00, 8'h80};
    rx_vecs[3].exp_addr = 32'hFFFF_FFFF;  rx_vecs[3].exp_data = 32'h8000_0000;

    tx_vecs[0].word = 32'h1234_5678;  tx_vecs[0].toggle = 1'b1;
    tx_vecs[0].exp  = '{8'h78, 8'h56, 8'h34, 8'h12};
    tx_vecs[1].word = 32'hA1B2_C3D4;  tx_vecs[1].toggle = 1'b0;
    tx_vecs[1].exp  = '{8'hD4, 8'hC3, 8'hB2, 8'hA1};

    // Reset state
    #2;
    check("rst_stream_v", {31'd0, stream_v_out}, 32'd0);
    check("rst_tx_v", {31'd0, tx_v}, 32'd0);
    check("rst_addr", stream_addr, 32'd0);
    check("rst_data", stream_data_out, 32'd0);
    #10 reset_n = 1'b1;
    @(posedge clk);
    #1;
    check("rst_rx_ready", {31'd0, rx_ready}, 32'd1);
    check("rst_stream_ready", {31'd0, stream_ready}, 32'd1);

    // Frame table, yumi tied high
    stream_yumi = 1'b1;
    for (int i = 0; i < 4; i++) begin
      base  = wr_addr_q.size();
      vbase = v_cycles;
      send_frame(rx_vecs[i].b);
      @(negedge clk);
      check("issue_latency", {31'd0, stream_v_out}, 32'd1);
      repeat (3) @(posedge clk);
      #1;
      check("frame_write_count", wr_addr_q.size() - base, 32'd1);
      if (wr_addr_q.size() > base) begin
        check("frame_addr", wr_addr_q[base], rx_vecs[i].exp_addr);
        check("frame_data", wr_data_q[base], rx_vecs[i].exp_data);
      end
      check("frame_v_cycles", v_cycles - vbase, 32'd1);
    end

    // Delayed yumi: valid held six cycles, fields stable, RX stalled
    stream_yumi = 1'b0;
    base  = wr_addr_q.size();
    vbase = v_cycles;
    send_frame(rx_vecs[1].b);
    for (int i = 0; i < 6; i++) begin
      stream_yumi = (i == 5);
      @(negedge clk);
      check("stall_v", {31'd0, stream_v_out}, 32'd1);
      check("stall_rx_ready", {31'd0, rx_ready}, 32'd0);
      check("stall_addr", stream_addr, rx_vecs[1].exp_addr);
      check("stall_data", stream_data_out, rx_vecs[1].exp_data);
      @(posedge clk);
      #1;
    end
    stream_yumi = 1'b0;
    @(negedge clk);
    check("stall_release_v", {31'd0, stream_v_out}, 32'd0);
    check("stall_release_rx_ready", {31'd0, rx_ready}, 32'd1);
    @(posedge clk);
    #1;
    check("stall_v_cycles", v_cycles - vbase, 32'd6);
    check("stall_write_count", wr_addr_q.size() - base, 32'd1);

    // TX word table
    for (int i = 0; i < 2; i++) begin
      run_tx(tx_vecs[i].word, tx_vecs[i].toggle, got, n, el_tx_a);
      check("tx_byte_count", n, 32'd4);
      for (int k = 0; k < 4; k++) check("tx_byte", {24'd0, got[k]}, {24'd0, tx_vecs[i].exp[k]});
    end

    // Reset mid-frame and mid-word
    stream_yumi    = 1'b1;
    tx_ready       = 1'b0;
    stream_v_in    = 1'b1;
    stream_data_in = 32'hCAFE_F00D;
    @(posedge clk);
    #1 stream_v_in = 1'b0;
    send_byte(8'h99);
    send_byte(8'h88);
    send_byte(8'h77);
    #2 reset_n = 1'b0;
    #1;
    check("midrst_rx_ready", {31'd0, rx_ready}, 32'd1);
    check("midrst_stream_ready", {31'd0, stream_ready}, 32'd1);
    check("midrst_tx_v", {31'd0, tx_v}, 32'd0);
    check("midrst_stream_v", {31'd0, stream_v_out}, 32'd0);
    check("midrst_frame", stream_data_out, 32'd0);
    @(posedge clk);
    #1 reset_n = 1'b1;
    @(posedge clk);
    #1;
    tx_ready = 1'b1;
    base = wr_addr_q.size();
    send_frame(rx_vecs[2].b);
    repeat (3) @(posedge clk);
    #1;
    check("postrst_write_count", wr_addr_q.size() - base, 32'd1);
    if (wr_addr_q.size() > base) begin
      check("postrst_addr", wr_addr_q[base], 32'h0000_0020);
      check("postrst_data", wr_data_q[base], 32'h0000_0001);
    end
    n = 0;
    repeat (6) begin
      @(negedge clk);
      if (tx_v) n++;
    end
    check("postrst_no_tx_replay", n, 32'd0);
    tx_ready = 1'b0;
    @(posedge clk);
    #1;

    // Concurrency: each path alone, then both together
    stream_yumi = 1'b1;
    run_rx(rx_vecs[0].b, el_rx_a);
    run_tx(32'h1234_5678, 1'b0, got, n, el_tx_a);
    fork
      run_rx(rx_vecs[3].b, el_rx_b);
      begin
        logic [7:0] g2 [4];
        int n2;
        run_tx(32'h1234_5678, 1'b0, g2, n2, el_tx_b);
        check("conc_tx_count", n2, 32'd4);
        check("conc_tx_last", {24'd0, g2[3]}, 32'h12);
      end
    join
    check("conc_rx_cycles", el_rx_b, el_rx_a);
    check("conc_tx_cycles", el_tx_b, el_tx_a);
    check("conc_rx_addr", wr_addr_q[wr_addr_q.size()-1], 32'hFFFF_FFFF);

`ifdef BP_STREAM_UART_SYNC_EN
    // Hunt: bytes before 8'hA5 are dropped
    base = wr_addr_q.size();
    send_byte(8'h00);
    send_byte(8'hFF);
    repeat (3) @(posedge clk);
    #1;
    check("hunt_no_write", wr_addr_q.size() - base, 32'd0);
    send_byte(8'hA5);
    for (int i = 0; i < 8; i++) send_byte(rx_vecs[0].b[i]);
    repeat (3) @(posedge clk);
    #1;
    check("hunt_write_count", wr_addr_q.size() - base, 32'd1);
    if (wr_addr_q.size() > base) begin
      check("hunt_addr", wr_addr_q[base], 32'h0000_0010);
      check("hunt_data", wr_data_q[base], 32'hDEAD_BEEF);
    end
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/bp_stream_uart_master.md
BP_STREAM_UART_MASTER -- requirements
Module: bp_stream_uart_master

Interface
REQ-001 SHALL have parameter stream_addr_width_p, default 32, width of the address field of a stream write; multiple of 8.
REQ-002 SHALL have parameter stream_data_width_p, default 32, width of the data field of stream words in both directions; multiple of 8.
REQ-003 SHALL have port clk_i  input  1  sole clock; all state is updated on its rising edge.
REQ-004 SHALL have port reset_n_i  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port rx_v_i  input  1  host byte valid.
REQ-006 SHALL have port rx_data_i  input  8  host byte.
REQ-007 SHALL have port rx_ready_o  output  1  byte accepted when rx_v_i & rx_ready_o.
REQ-008 SHALL have port stream_v_o  output  1  stream write valid toward the stream host.
REQ-009 SHALL have port stream_addr_o  output  stream_addr_width_p  stream write address.
REQ-010 SHALL have port stream_data_o  output  stream_data_width_p  stream write data.
REQ-011 SHALL have port stream_yumi_i  input  1  stream host consumed the current write.
REQ-012 SHALL have port stream_v_i  input  1  return word valid from the stream host.
REQ-013 SHALL have port stream_data_i  input  stream_data_width_p  return word.
REQ-014 SHALL have port stream_ready_o  output  1  return word accepted when stream_v_i & stream_ready_o.
REQ-015 SHALL have port tx_v_o  output  1  byte valid toward the host.
REQ-016 SHALL have port tx_data_o  output  8  byte toward the host.
REQ-017 SHALL have port tx_ready_i  input  1  byte taken when tx_v_o & tx_ready_i.

Function
REQ-018 SHALL define frame length F = (stream_addr_width_p + stream_data_width_p)/8 bytes: address bytes first, then data bytes, each field least-significant byte first.
REQ-019 SHALL run an RX FSM with states COLLECT and ISSUE; rx_ready_o = 1 exactly in COLLECT.
REQ-020 SHALL, in COLLECT, shift each accepted byte into the frame register and increment a byte counter; on acceptance of byte F-1, clear the counter and enter ISSUE on the next cycle.
REQ-021 SHALL, in ISSUE, assert stream_v_o with stream_addr_o/stream_data_o held constant until stream_yumi_i, then return to COLLECT on the next cycle; stream_yumi_i outside ISSUE is ignored.
REQ-022 SHALL give a latency of one cycle from acceptance of the final frame byte to stream_v_o high.
REQ-023 SHALL run a TX FSM with states IDLE and SEND; stream_ready_o = 1 exactly in IDLE.
REQ-024 SHALL, in IDLE, capture stream_data_i on stream_v_i and enter SEND, with tx_v_o high on the next cycle.
REQ-025 SHALL, in SEND, present byte k (k = 0 to stream_data_width_p/8-1, LSB first) on tx_data_o, advance k only on tx_v_o & tx_ready_i, and return to IDLE after the last byte is taken.
REQ-026 SHALL hold tx_data_o stable while tx_v_o & !tx_ready_i.
REQ-027 SHALL operate the RX and TX FSMs independently; simultaneous activity on both paths causes no stall or interaction.
REQ-028 SHALL let the byte counters wrap only at frame or word end, never mid-field.

Reset
REQ-029 SHALL, while reset_n_i = 0, immediately drive RX to COLLECT and TX to IDLE, clear both counters and both data registers, and force stream_v_o = 0 and tx_v_o = 0, with rx_ready_o = 1 and stream_ready_o = 1 after release.
REQ-030 SHALL discard any partial frame or partially sent word when reset asserts mid-operation; nothing is replayed after release.

Configuration
REQ-031 SHALL support macro BP_STREAM_UART_SYNC_EN; when defined, RX adds a state HUNT (the reset state) that accepts and drops bytes until 8'hA5, then enters COLLECT, and ISSUE returns to HUNT.
REQ-032 SHALL, without BP_STREAM_UART_SYNC_EN, have no HUNT state; every byte is frame payload, as in REQ-019 to REQ-021.

Verification
REQ-033 SHALL check: bytes 10 00 00 00 EF BE AD DE, stream_yumi_i tied high -> single stream write addr 32'h00000010, data 32'hDEADBEEF, stream_v_o one cycle.
REQ-034 SHALL check: a frame whose stream_yumi_i is delayed 5 cycles -> stream_v_o high 5+1 cycles, address and data stable, rx_ready_o = 0 throughout.
REQ-035 SHALL check: stream_data_i = 32'h12345678, tx_ready_i toggling -> tx bytes 78 56 34 12 in order, stream_ready_o = 0 until the last byte is taken.
REQ-036 SHALL check: reset_n_i pulsed low after 3 frame bytes, then a full frame of 20 00 00 00 01 00 00 00 -> single write addr 32'h20, data 32'h1.
REQ-037 SHALL check: an RX frame concurrent with a TX word -> both complete with no extra cycles versus running alone.
REQ-038 SHALL check, with BP_STREAM_UART_SYNC_EN: bytes 00 FF A5 then 8 frame bytes -> single correct write; the leading 00 FF produce no write.
